// File: rtl/pwm_capture_if.sv
// PWM capture bus: pulse input towards the block, measurement results back out.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             pwm_in;
    logic             level;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             valid;
    logic             stale;

    // Driver side: owns the pulse input, observes the results.
    modport master (
        output pwm_in,
        input  level, high_cnt, period_cnt, valid, stale
    );

    // Capture block side.
    modport slave (
        input  pwm_in,
        output level, high_cnt, period_cnt, valid, stale
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an asynchronous pulse train, measures high time
// and rise-to-rise period in clk cycles, and flags a stalled input.
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_capture_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nx;
    logic             s1, s2, p;
    logic             rise, fall;
    logic [CNT_W-1:0] pc, pc_nx, pc_inc;
    logic [CNT_W-1:0] hl, hl_nx;
    logic             at_max;
    logic             meas_done;
    logic             timeout;
    logic [CNT_W-1:0] high_q, period_q;
    logic             valid_q, stale_q;

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            p  <= 1'b0;
        end else begin
            s1 <= bus.pwm_in;
            s2 <= s1;
            p  <= s2;
        end
    end

    assign rise   = s2 & ~p;
    assign fall   = ~s2 & p;
    assign at_max = (pc == CNT_MAX);
    // Counter saturates instead of wrapping so a stuck input times out cleanly.
    assign pc_inc = at_max ? CNT_MAX : pc + CNT_ONE;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: an edge always wins over the saturation timeout.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (rise) state_nx = HIGH;
            HIGH: begin
                if (fall)        state_nx = LOW;
                else if (at_max) state_nx = IDLE;
            end
            LOW: begin
                if (rise)        state_nx = HIGH;
                else if (at_max) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Per-state counter/latch updates and measurement/timeout events.
    always_comb begin
        pc_nx     = pc;
        hl_nx     = hl;
        meas_done = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: if (rise) pc_nx = CNT_ONE;
            HIGH: begin
                pc_nx = pc_inc;
                if (fall)        hl_nx   = pc;
                else if (at_max) timeout = 1'b1;
            end
            LOW: begin
                if (rise) begin
                    pc_nx     = CNT_ONE;
                    meas_done = 1'b1;
                end else begin
                    pc_nx = pc_inc;
                    if (at_max) timeout = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Counters and registered results; results only move on a measurement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= '0;
            hl       <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stale_q  <= 1'b1;
        end else begin
            pc      <= pc_nx;
            hl      <= hl_nx;
            valid_q <= meas_done;
            if (meas_done) begin
                high_q   <= hl;
                period_q <= pc;
                stale_q  <= 1'b0;
            end else if (timeout) begin
                stale_q <= 1'b1;
            end
        end
    end

    assign bus.level      = s2;
    assign bus.high_cnt   = high_q;
    assign bus.period_cnt = period_q;
    assign bus.valid      = valid_q;
    assign bus.stale      = stale_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed scenarios plus random pulse trains, checked
// every cycle against a timestamp-based reference model.
module tb_pwm_capture;
    localparam int W   = 8;
    localparam int MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_capture_if #(.CNT_W(W)) bus();
    pwm_capture #(.CNT_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    int vcount = 0;

    // Reference model: input history as seen through the 2-cycle synchronizer
    // delay, and timestamps of the last qualifying edge.
    int         cyc = 0;
    bit         smp [3] = '{0, 0, 0};   // smp[0] = newest sample
    int         phase = 0;              // 0 disarmed, 1 measuring high, 2 measuring low
    int         t_rise = 0;
    int         m_hl = 0;
    logic [W-1:0] e_high = '0, e_period = '0;
    logic       e_valid = 1'b0, e_stale = 1'b1, e_level = 1'b0;

    task automatic model(input bit v, input bit rst);
        bit r, f;
        int el, elc;
        cyc++;
        if (rst) begin
            smp = '{0, 0, 0};
            phase = 0; e_valid = 0; e_high = '0; e_period = '0;
            e_stale = 1; e_level = 0;
            return;
        end
        // Edge seen by the logic at this clock is the level change delayed by two samples.
        r   = smp[1] & ~smp[2];
        f   = ~smp[1] & smp[2];
        el  = cyc - t_rise;
        elc = (el > MAX) ? MAX : el;
        e_valid = 0;
        case (phase)
            0: if (r) begin t_rise = cyc; phase = 1; end
            1: begin
                if (f) begin m_hl = elc; phase = 2; end
                else if (el >= MAX) begin phase = 0; e_stale = 1; end
            end
            default: begin
                if (r) begin
                    e_valid = 1; e_high = W'(m_hl); e_period = W'(elc);
                    e_stale = 0; t_rise = cyc; phase = 1;
                end else if (el >= MAX) begin
                    phase = 0; e_stale = 1;
                end
            end
        endcase
        e_level = smp[0];
        smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = v;
    endtask

    task automatic check_outputs();
        n_chk++;
        assert (bus.valid === e_valid) else begin
            n_fail++; $error("FAIL valid cyc=%0d observed=%b expected=%b", cyc, bus.valid, e_valid);
        end
        n_chk++;
        assert (bus.stale === e_stale) else begin
            n_fail++; $error("FAIL stale cyc=%0d observed=%b expected=%b", cyc, bus.stale, e_stale);
        end
        n_chk++;
        assert (bus.level === e_level) else begin
            n_fail++; $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, bus.level, e_level);
        end
        n_chk++;
        assert (bus.high_cnt === e_high) else begin
            n_fail++; $error("FAIL high_cnt cyc=%0d observed=%0d expected=%0d", cyc, bus.high_cnt, e_high);
        end
        n_chk++;
        assert (bus.period_cnt === e_period) else begin
            n_fail++; $error("FAIL period_cnt cyc=%0d observed=%0d expected=%0d", cyc, bus.period_cnt, e_period);
        end
    endtask

    // Directed check against a constant taken from the scenario description.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++; $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, model the rising edge, sample at the next falling edge.
    task automatic tick(input bit v, input bit rst);
        bus.pwm_in = v;
        rst_n = !rst;
        @(posedge clk);
        model(v, rst);
        @(negedge clk);
        check_outputs();
        if (bus.valid === 1'b1) vcount++;
    endtask

    task automatic hi(input int n); repeat (n) tick(1'b1, 1'b0); endtask
    task automatic lo(input int n); repeat (n) tick(1'b0, 1'b0); endtask
    task automatic pulse(input int h, input int l); hi(h); lo(l); endtask

    initial begin
        bus.pwm_in = 1'b0;
        @(negedge clk);

        // Reset held with a toggling input.
        for (int i = 0; i < 4; i++) tick(i[0], 1'b1);
        chk("rst_stale", 32'(bus.stale), 1);
        lo(3);

        // First rise after reset only arms; then a steady 10/30 square wave.
        vcount = 0;
        for (int i = 0; i < 6; i++) pulse(10, 30);
        chk("sq_vcount", vcount, 5);
        chk("sq_high", 32'(bus.high_cnt), 10);
        chk("sq_period", 32'(bus.period_cnt), 40);
        chk("sq_stale", 32'(bus.stale), 0);

        // Minimum pulse: 1 high, 4 low.
        vcount = 0;
        for (int i = 0; i < 6; i++) pulse(1, 4);
        chk("min_vcount", vcount, 6);
        chk("min_high", 32'(bus.high_cnt), 1);
        chk("min_period", 32'(bus.period_cnt), 5);

        // Timeout with the input stuck high after a good measurement.
        for (int i = 0; i < 2; i++) pulse(10, 30);
        vcount = 0;
        hi(300);
        chk("to_vcount", vcount, 1);
        chk("to_stale", 32'(bus.stale), 1);
        chk("to_high", 32'(bus.high_cnt), 10);
        chk("to_period", 32'(bus.period_cnt), 40);
        lo(20);
        vcount = 0;
        pulse(10, 30);
        chk("rearm_novalid", vcount, 0);
        pulse(10, 30);
        chk("rearm_vcount", vcount, 1);
        chk("rearm_stale", 32'(bus.stale), 0);

        // Saturation boundary: period of exactly max measures, one more times out.
        pulse(5, 250);
        pulse(5, 250);
        hi(5);
        chk("sat_period", 32'(bus.period_cnt), MAX);
        chk("sat_high", 32'(bus.high_cnt), 5);
        chk("sat_stale", 32'(bus.stale), 0);
        lo(251);
        vcount = 0;
        pulse(5, 10);
        chk("sat_to_stale", 32'(bus.stale), 1);
        chk("sat_to_vcount", vcount, 0);
        chk("sat_to_period", 32'(bus.period_cnt), MAX);

        // Reset pulse in the middle of a high phase.
        for (int i = 0; i < 2; i++) pulse(10, 30);
        hi(4);
        tick(1'b1, 1'b1);
        chk("mid_rst_stale", 32'(bus.stale), 1);
        chk("mid_rst_period", 32'(bus.period_cnt), 0);
        lo(5);
        vcount = 0;
        pulse(7, 13);
        chk("mid_rst_novalid", vcount, 0);
        hi(5);
        chk("mid_rst_vcount", vcount, 1);
        chk("mid_rst_high", 32'(bus.high_cnt), 7);
        chk("mid_rst_period2", 32'(bus.period_cnt), 20);
        lo(10);

        // Random pulse trains, occasionally long enough to saturate.
        for (int i = 0; i < 60; i++) begin
            int h, l;
            h = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 20);
            l = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 40);
            pulse(h, l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
